acia_rx: RTL
============

ACIA_RX -- requirements
Module: acia_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of clk flops synchronising RxC, RxD and DCD.
REQ-002 The block SHALL have port clk, input, 1 bit: the single 16/13 MHz system clock; all flops SHALL be clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port RxC, input, 1 bit: receive clock from the serial ULA.
REQ-005 The block SHALL have port RxD, input, 1 bit: receive data from the serial ULA.
REQ-006 The block SHALL have port DCD, input, 1 bit: carrier-detect from the serial ULA.
REQ-007 The block SHALL have port div_sel, input, 2 bits: divide ratio, 00=/1, 01=/16, 10=/64, 11=receiver held reset.
REQ-008 The block SHALL have port rd, input, 1 bit: one-clk pop strobe.
REQ-009 The block SHALL have port rx_data, output, 8 bits: head received byte.
REQ-010 The block SHALL have port rdrf, output, 1 bit: byte available.
REQ-011 The block SHALL have port fe, output, 1 bit: framing error of head byte.
REQ-012 The block SHALL have port ovrn, output, 1 bit: sticky overrun flag.
REQ-013 The block SHALL have port dcd_lost, output, 1 bit: sticky flag, set when carrier is lost.

Function
REQ-014 A "tick" SHALL be one clk cycle in which synchronised RxC is 1 and its previous value was 0; all bit timing SHALL count ticks only.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP, and SHALL be in IDLE out of reset.
REQ-016 In IDLE, when a tick samples RxD=0: in /1 mode the FSM SHALL go to DATA; in /16 and /64 modes it SHALL go to START with tick counter=0.
REQ-017 In START, after 8 ticks (/16) or 32 ticks (/64), RxD SHALL be resampled; if 1 the FSM SHALL return to IDLE (false start, no flags); if 0 it SHALL go to DATA.
REQ-018 In DATA, one bit SHALL be sampled every 16 (/16), 64 (/64) or 1 (/1) ticks, LSB first, into an 8-bit shift register; after the 8th bit the FSM SHALL go to STOP.
REQ-019 In STOP, the stop bit SHALL be sampled at the same spacing; the byte SHALL be pushed with fe=~stop_bit, and the FSM SHALL return to IDLE in the same cycle.
REQ-020 rdrf, rx_data and fe SHALL be registered and valid on the clk after the stop-bit sample cycle.
REQ-021 rd with rdrf=1 SHALL pop the head; rd with rdrf=0 SHALL be ignored.
REQ-022 A push while the store is full SHALL discard the new byte and set ovrn; rd SHALL clear ovrn.
REQ-023 Simultaneous rd and push when full SHALL pop then store, with no overrun.
REQ-024 While synchronised DCD=1 the FSM SHALL be forced to IDLE, aborting any frame without a push; a 0->1 DCD transition SHALL set dcd_lost, and rd SHALL clear dcd_lost.
REQ-025 div_sel=11 SHALL act as rst for the FSM, the store and all flags; div_sel SHALL be sampled continuously, and a change mid-frame SHALL take effect at the next sample point.
REQ-026 The tick counter SHALL be 6 bits wide and wrap to 0 at each sample point.

Reset
REQ-027 rst SHALL force the FSM to IDLE, zero the tick and bit counters, empty the store, and set rx_data=0x00, rdrf=0, fe=0, ovrn=0 and dcd_lost=0 on the next clk edge.
REQ-028 A rst asserted mid-frame SHALL discard the partial byte, and the first falling RxD after rst deasserts SHALL be treated as a new start bit.

Configuration
REQ-029 With macro ACIA_RX_FIFO_EN defined, the store SHALL be a 4-entry FIFO with per-entry fe, rdrf=not empty, and "full" meaning 4 entries.
REQ-030 Without ACIA_RX_FIFO_EN, the store SHALL be a single holding register, with "full" equal to rdrf.

Verification
REQ-031 /16 mode, frame 0xA5 with stop=1 and 16 RxC edges per bit -> rdrf=1, rx_data=0xA5, fe=0; after rd, rdrf=0.
REQ-032 /16 mode, RxD low for 4 ticks then high -> FSM returns to IDLE, rdrf stays 0, no flags set.
REQ-033 /64 mode, frame 0x3C with stop=0 -> rdrf=1, rx_data=0x3C, fe=1.
REQ-034 No rd issued: without the macro, 0x11 then 0x22 -> rx_data=0x11, ovrn=1; with the macro, 0x01..0x05 -> pops return 0x01..0x04, ovrn=1.
REQ-035 DCD raised after the 3rd data bit of 0x55 -> no push, dcd_lost=1; after DCD=0, a clean 0x66 frame -> rdrf=1, rx_data=0x66.
REQ-036 rst pulsed mid-frame of 0x77, then full frame 0x88 -> only 0x88 received, all flags 0.

Source files
------------

// File: rtl/acia_rx.sv
// ============================================================================
//  Module   : acia_rx
//  Purpose  : 6850-style ACIA receiver. It takes RxC/RxD/DCD from the serial
//             ULA and divides RxC by 1, 16 or 64. Received bytes go into a
//             holding register, or into a 4-entry FIFO when ACIA_RX_FIFO_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acia_rx #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxC,
    input  logic       RxD,
    input  logic       DCD,
    input  logic [1:0] div_sel,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rdrf,
    output logic       fe,
    output logic       ovrn,
    output logic       dcd_lost
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam logic [1:0] c_DIV_1   = 2'b00;
    localparam logic [1:0] c_DIV_16  = 2'b01;
    localparam logic [1:0] c_DIV_64  = 2'b10;
    localparam logic [1:0] c_DIV_OFF = 2'b11;

    logic [SYNC_STAGES-1:0] r_rxc_sync;
    logic [SYNC_STAGES-1:0] r_rxd_sync;
    logic [SYNC_STAGES-1:0] r_dcd_sync;
    logic                   r_rxc_prev;
    logic                   r_dcd_prev;

    logic       w_rxc_s;
    logic       w_rxd_s;
    logic       w_dcd_s;
    logic       w_tick;
    logic       w_dcd_rise;
    logic       w_clr;
    logic [6:0] w_period;
    logic [6:0] w_half;
    logic [6:0] w_cnt_next;
    logic       w_at_full;
    logic       w_at_half;

    state_t     r_state;
    logic [5:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;

    logic       w_push;
    logic       w_push_fe;
    logic       w_pop;
    logic       w_full;

    // Line idle values are loaded at reset so no false edge appears on exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxc_sync <= '1;
            r_rxd_sync <= '1;
            r_dcd_sync <= '0;
            r_rxc_prev <= 1'b1;
            r_dcd_prev <= 1'b0;
        end else begin
            r_rxc_sync <= {r_rxc_sync[SYNC_STAGES-2:0], RxC};
            r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], RxD};
            r_dcd_sync <= {r_dcd_sync[SYNC_STAGES-2:0], DCD};
            r_rxc_prev <= w_rxc_s;
            r_dcd_prev <= w_dcd_s;
        end
    end

    assign w_rxc_s    = r_rxc_sync[SYNC_STAGES-1];
    assign w_rxd_s    = r_rxd_sync[SYNC_STAGES-1];
    assign w_dcd_s    = r_dcd_sync[SYNC_STAGES-1];
    assign w_tick     = w_rxc_s & ~r_rxc_prev;
    assign w_dcd_rise = w_dcd_s & ~r_dcd_prev;
    assign w_clr      = rst | (div_sel == c_DIV_OFF);

    always_comb begin
        w_period = 7'd1;
        w_half   = 7'd1;
        case (div_sel)
            c_DIV_16: begin
                w_period = 7'd16;
                w_half   = 7'd8;
            end
            c_DIV_64: begin
                w_period = 7'd64;
                w_half   = 7'd32;
            end
            default: begin
                w_period = 7'd1;
                w_half   = 7'd1;
            end
        endcase
    end

    // ">=" lets a mid-frame switch to a shorter ratio sample at the next tick
    assign w_cnt_next = {1'b0, r_tick_cnt} + 7'd1;
    assign w_at_full  = (w_cnt_next >= w_period);
    assign w_at_half  = (w_cnt_next >= w_half);

    assign w_push    = w_tick && (r_state == S_STOP) && w_at_full && !w_dcd_s && !w_clr;
    assign w_push_fe = ~w_rxd_s;
    assign w_pop     = rd & rdrf;

    always_ff @(posedge clk) begin
        if (w_clr || w_dcd_s) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rxd_s) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= (div_sel == c_DIV_1) ? S_DATA : S_START;
                    end
                end
                S_START: begin
                    if (w_at_half) begin
                        r_tick_cnt <= '0;
                        r_state    <= w_rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 6'd1;
                    end
                end
                S_DATA: begin
                    if (w_at_full) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rxd_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 6'd1;
                    end
                end
                S_STOP: begin
                    if (w_at_full) begin
                        r_tick_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ACIA_RX_FIFO_EN
    logic [8:0] r_mem [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       w_store;

    assign w_full  = (r_count == 3'd4);
    assign w_store = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_mem[r_wr_ptr] <= {w_push_fe, r_shift};
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_count <= r_count + {2'b00, w_store} - {2'b00, w_pop};
        end
    end

    assign rdrf    = (r_count != 3'd0);
    assign rx_data = r_mem[r_rd_ptr][7:0];
    assign fe      = rdrf & r_mem[r_rd_ptr][8];
`else
    logic [7:0] r_data;
    logic       r_fe;
    logic       r_full;

    assign w_full = r_full;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_data <= '0;
            r_fe   <= 1'b0;
            r_full <= 1'b0;
        end else if (w_push && (!r_full || w_pop)) begin
            r_data <= r_shift;
            r_fe   <= w_push_fe;
            r_full <= 1'b1;
        end else if (w_pop) begin
            r_fe   <= 1'b0;
            r_full <= 1'b0;
        end
    end

    assign rdrf    = r_full;
    assign rx_data = r_data;
    assign fe      = r_fe;
`endif

    logic r_ovrn;
    logic r_dcd_lost;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_ovrn     <= 1'b0;
            r_dcd_lost <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_ovrn <= 1'b1;
            end else if (rd) begin
                r_ovrn <= 1'b0;
            end
            if (w_dcd_rise) begin
                r_dcd_lost <= 1'b1;
            end else if (rd) begin
                r_dcd_lost <= 1'b0;
            end
        end
    end

    assign ovrn     = r_ovrn;
    assign dcd_lost = r_dcd_lost;

endmodule

`default_nettype wire
